instruction_cache_controller: RTL and testbench

Direct-mapped instruction cache sitting between the instruction prefetch buffer and the external memory bus. It serves whole 4-word (128-bit) line requests from the prefetch buffer, returning hits from an internal tag/data array and filling misses with four single-word memory reads. Its request/wait protocol is the prefetch buffer's cache-side protocol, so the two blocks connect directly.

---
 rtl/instruction_cache_controller_pkg.sv | 20 ++
 rtl/icache_tag_data_array.sv | 48 ++++
 rtl/instruction_cache_controller.sv | 119 +++++++++++
 tb/tb_instruction_cache_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_cache_controller_pkg.sv
// Shared widths, FSM encoding and zero constants for the direct-mapped instruction cache.
package instruction_cache_controller_pkg;

   localparam int unsigned AddrWidth    = 32;
   localparam int unsigned InstrWidth   = 32;
   localparam int unsigned WordsPerLine = 4;
   localparam int unsigned LineWidth    = InstrWidth * WordsPerLine;
   localparam int unsigned OffsetWidth  = 4;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLookup = 2'd1,
      StFill   = 2'd2,
      StDone   = 2'd3
   } icache_state_e;

   localparam logic [AddrWidth-1:0] AddressBusZero = '0;
   localparam logic [LineWidth-1:0] LineZero       = '0;

endpackage

// File: rtl/icache_tag_data_array.sv
// Tag/data register array with per-line valid bits, global clear and one write port.
module icache_tag_data_array
   import instruction_cache_controller_pkg::*;
#(
   parameter int unsigned LINES  = 64,
   parameter int unsigned IDX    = 6,
   parameter int unsigned TAG_W  = 22,
   parameter int unsigned LINE_W = LineWidth
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              invalidate,
   input  logic [IDX-1:0]    read_index,
   output logic              read_valid,
   output logic [TAG_W-1:0]  read_tag,
   output logic [LINE_W-1:0] read_data,
   input  logic              write_enable,
   input  logic [IDX-1:0]    write_index,
   input  logic [TAG_W-1:0]  write_tag,
   input  logic [LINE_W-1:0] write_data
);

   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [LINE_W-1:0] data_q [LINES];

   // A write on the same edge as a flush still lands valid: the later assignment wins.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
      end else begin
         if (invalidate) valid_q <= '0;
         if (write_enable) valid_q[write_index] <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (write_enable) begin
         tag_q[write_index]  <= write_tag;
         data_q[write_index] <= write_data;
      end
   end

   assign read_valid = valid_q[read_index];
   assign read_tag   = tag_q[read_index];
   assign read_data  = data_q[read_index];

endmodule

// File: rtl/instruction_cache_controller.sv
// Direct-mapped instruction cache: serves 4-word line requests, fills misses with 4 word reads.
module instruction_cache_controller
   import instruction_cache_controller_pkg::*;
#(
   parameter int unsigned LINES  = 64,
   parameter int unsigned ADDR_W = AddrWidth,
   parameter int unsigned LINE_W = LineWidth
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  prefetch_request,
   input  logic [ADDR_W-1:0]     prefetch_address,
   output logic [LINE_W-1:0]     prefetch_instructions,
   output logic                  prefetch_wait,
   input  logic                  invalidate,
   output logic                  mem_request,
   output logic [ADDR_W-1:0]     mem_address,
   input  logic [InstrWidth-1:0] mem_data,
   input  logic                  mem_wait
);

   localparam int unsigned IDX    = $clog2(LINES);
   localparam int unsigned LADR_W = ADDR_W - OffsetWidth;
   localparam int unsigned TAG_W  = LADR_W - IDX;

   icache_state_e                 state_q;
   logic [LADR_W-1:0]             req_line_q;
   logic [1:0]                    beat_q;
   logic [2:0][InstrWidth-1:0]    fill_q;

   logic [IDX-1:0]    index;
   logic [TAG_W-1:0]  tag;
   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [LINE_W-1:0] rd_data;
   logic              hit;
   logic              beat_accept;
   logic              fill_last;
   logic [LINE_W-1:0] fill_line;
   logic              unused_offset;

   assign index         = req_line_q[IDX-1:0];
   assign tag           = req_line_q[LADR_W-1:IDX];
   assign hit           = rd_valid && (rd_tag == tag);
   assign beat_accept   = (state_q == StFill) && mem_request && !mem_wait;
   assign fill_last     = beat_accept && (beat_q == 2'd3);
   assign fill_line     = {mem_data, fill_q[2], fill_q[1], fill_q[0]};
   assign prefetch_wait = prefetch_request && (state_q != StDone);
   assign unused_offset = ^prefetch_address[OffsetWidth-1:0];

   icache_tag_data_array #(
      .LINES  (LINES),
      .IDX    (IDX),
      .TAG_W  (TAG_W),
      .LINE_W (LINE_W)
   ) u_array (
      .clock        (clock),
      .reset        (reset),
      .invalidate   (invalidate),
      .read_index   (index),
      .read_valid   (rd_valid),
      .read_tag     (rd_tag),
      .read_data    (rd_data),
      .write_enable (fill_last),
      .write_index  (index),
      .write_tag    (tag),
      .write_data   (fill_line)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q               <= StIdle;
         req_line_q            <= '0;
         beat_q                <= 2'd0;
         fill_q                <= '0;
         mem_request           <= 1'b0;
         mem_address           <= ADDR_W'(AddressBusZero);
         prefetch_instructions <= LINE_W'(LineZero);
      end else begin
         unique case (state_q)
            StIdle: begin
               if (prefetch_request) begin
                  req_line_q <= prefetch_address[ADDR_W-1:OffsetWidth];
                  state_q    <= StLookup;
               end
            end
            StLookup: begin
               if (hit) begin
                  prefetch_instructions <= rd_data;
                  state_q               <= StDone;
               end else begin
                  beat_q      <= 2'd0;
                  mem_request <= 1'b1;
                  mem_address <= {req_line_q, 4'b0000};
                  state_q     <= StFill;
               end
            end
            StFill: begin
               if (beat_accept) begin
                  beat_q      <= beat_q + 2'd1;
                  mem_address <= mem_address + ADDR_W'(4);
                  if (fill_last) begin
                     mem_request           <= 1'b0;
                     prefetch_instructions <= fill_line;
                     state_q               <= StDone;
                  end else begin
                     fill_q[beat_q] <= mem_data;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Directed bench for instruction_cache_controller: memory returns data equal to word address.
module tb_instruction_cache_controller;

   logic         clock;
   logic         reset;
   logic         prefetch_request;
   logic [31:0]  prefetch_address;
   logic [127:0] prefetch_instructions;
   logic         prefetch_wait;
   logic         invalidate;
   logic         mem_request;
   logic [31:0]  mem_address;
   logic [31:0]  mem_data;
   logic         mem_wait;

   int checks = 0;
   int passed = 0;

   instruction_cache_controller #(
      .LINES  (64),
      .ADDR_W (32),
      .LINE_W (128)
   ) dut (
      .clock                 (clock),
      .reset                 (reset),
      .prefetch_request      (prefetch_request),
      .prefetch_address      (prefetch_address),
      .prefetch_instructions (prefetch_instructions),
      .prefetch_wait         (prefetch_wait),
      .invalidate            (invalidate),
      .mem_request           (mem_request),
      .mem_address           (mem_address),
      .mem_data              (mem_data),
      .mem_wait              (mem_wait)
   );

   assign mem_data = mem_address;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0]  addr;
      int           stall_beat;
      int           stall_cycles;
      int           inv_cycle;
      int           exp_lat;
      int           exp_beats;
      logic [127:0] exp_line;
   } vec_t;

   vec_t vecs[13];

   function automatic logic [127:0] line_of(input logic [31:0] base);
      return {base + 32'hC, base + 32'h8, base + 32'h4, base};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Called #1 after a rising edge. Returns edges until wait dropped, beats seen, line, and
   // the wait level one cycle after DONE (request still high) and after the request drops.
   task automatic run_req(input logic [31:0] addr, input int stall_beat, input int stall_cycles,
                          input int inv_cycle, output int lat, output int beats,
                          output int addr_errs, output logic [127:0] line,
                          output logic wait_after, output logic wait_idle);
      int stalled;
      logic [31:0] base;
      bit done;
      base      = {addr[31:4], 4'h0};
      lat       = 0;
      beats     = 0;
      addr_errs = 0;
      stalled   = 0;
      done      = 0;
      line      = '0;
      prefetch_request = 1'b1;
      prefetch_address = addr;
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         invalidate = (lat == inv_cycle);
         if (mem_request && beats == stall_beat && stalled < stall_cycles) begin
            mem_wait = 1'b1;
            stalled++;
         end else begin
            mem_wait = 1'b0;
         end
         if (mem_request && !mem_wait) begin
            if (mem_address !== base + 32'(4 * beats)) addr_errs++;
            beats++;
         end
         if (!prefetch_wait) begin
            line = prefetch_instructions;
            done = 1;
            break;
         end
         @(posedge clock);
         lat++;
      end
      invalidate = 1'b0;
      mem_wait   = 1'b0;
      if (!done) lat = 999;
      @(posedge clock);
      #1;
      wait_after = prefetch_wait;
      prefetch_request = 1'b0;
      prefetch_address = 32'hDEAD_BEE0;
      #1;
      wait_idle = prefetch_wait;
   endtask

   int           lat, beats, aerr;
   logic [127:0] line;
   logic         w_after, w_idle;

   initial begin
      //          addr          sb  sc  inv lat bt  line
      vecs[0]  = '{32'h0000_0100, -1, 0, -1, 6, 4, line_of(32'h100)};
      vecs[1]  = '{32'h0000_010C, -1, 0, -1, 2, 0, line_of(32'h100)};
      vecs[2]  = '{32'h0000_0500, -1, 0, -1, 6, 4, line_of(32'h500)};
      vecs[3]  = '{32'h0000_0100, -1, 0, -1, 6, 4, line_of(32'h100)};
      vecs[4]  = '{32'h0000_0240,  2, 3, -1, 9, 4, line_of(32'h240)};
      vecs[5]  = '{32'h0000_0248, -1, 0, -1, 2, 0, line_of(32'h240)};
      vecs[6]  = '{32'h0000_0500, -1, 0, -1, 6, 4, line_of(32'h500)};
      vecs[7]  = '{32'h0000_0500, -1, 0,  0, 6, 4, line_of(32'h500)};
      vecs[8]  = '{32'h0000_0504, -1, 0,  1, 2, 0, line_of(32'h500)};
      vecs[9]  = '{32'h0000_0508, -1, 0, -1, 6, 4, line_of(32'h500)};
      vecs[10] = '{32'h0000_0380, -1, 0,  5, 6, 4, line_of(32'h380)};
      vecs[11] = '{32'h0000_038C, -1, 0, -1, 2, 0, line_of(32'h380)};
      vecs[12] = '{32'h0000_0508, -1, 0, -1, 6, 4, line_of(32'h500)};

      reset            = 1'b0;
      prefetch_request = 1'b0;
      prefetch_address = '0;
      invalidate       = 1'b0;
      mem_wait         = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset mem_request", 128'(mem_request), 128'd0);
      check("reset mem_address", 128'(mem_address), 128'd0);
      check("reset line", prefetch_instructions, 128'd0);
      check("reset wait", 128'(prefetch_wait), 128'd0);
      reset = 1'b1;
      @(posedge clock);
      #1;

      for (int i = 0; i < 13; i++) begin
         run_req(vecs[i].addr, vecs[i].stall_beat, vecs[i].stall_cycles, vecs[i].inv_cycle,
                 lat, beats, aerr, line, w_after, w_idle);
         check($sformatf("v%0d latency", i), 128'(lat), 128'(vecs[i].exp_lat));
         check($sformatf("v%0d mem beats", i), 128'(beats), 128'(vecs[i].exp_beats));
         check($sformatf("v%0d mem address errors", i), 128'(aerr), 128'd0);
         check($sformatf("v%0d line", i), line, vecs[i].exp_line);
         check($sformatf("v%0d wait high after DONE", i), 128'(w_after), 128'd1);
         check($sformatf("v%0d wait low when idle", i), 128'(w_idle), 128'd0);
      end

      // Reset during beat 1 of a fill: the beat is abandoned and the cache empties.
      prefetch_request = 1'b1;
      prefetch_address = 32'h0000_0100;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("midfill mem_request", 128'(mem_request), 128'd1);
      check("midfill mem_address", 128'(mem_address), 128'h104);
      reset = 1'b0;
      #1;
      check("async reset mem_request", 128'(mem_request), 128'd0);
      check("async reset mem_address", 128'(mem_address), 128'd0);
      check("async reset line", prefetch_instructions, 128'd0);
      prefetch_request = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      run_req(32'h0000_0100, -1, 0, -1, lat, beats, aerr, line, w_after, w_idle);
      check("post-reset 0x100 latency", 128'(lat), 128'd6);
      check("post-reset 0x100 addr errors", 128'(aerr), 128'd0);
      check("post-reset 0x100 line", line, line_of(32'h100));
      run_req(32'h0000_0380, -1, 0, -1, lat, beats, aerr, line, w_after, w_idle);
      check("post-reset 0x380 latency", 128'(lat), 128'd6);
      check("post-reset 0x380 line", line, line_of(32'h380));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
